sparkle_scheduler: RTL and testbench

SPARKLE_SCHEDULER -- requirements
Module: sparkle_scheduler

---
 rtl/sparkle_scheduler.sv | 196 +++++++++++++++++++
 tb/tb_sparkle_scheduler.sv | 459 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sparkle_scheduler.sv
// sparkle_scheduler: periodic LED sparkle generator behind a Wishbone register file.
// Each timer tick fetches one pseudorandom word and turns it into a pixel command
// (LED index scaled into COUNT, colour from the upper 24 bits).
// Optional per-channel brightness scaling is built when SPARKLE_BRIGHTNESS_EN is defined.
//
// state | meaning
// IDLE  | waiting for a timer tick
// REQ   | rnd_next pulsed, generator word captured
// CALC  | index and colour computed from the captured word
// OUT   | pix_valid held with stable data until pix_ready
module sparkle_scheduler #(
    parameter logic [15:0] RESET_PERIOD = 16'd1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [3:0]  wbs_sel_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic        rnd_next,
    input  logic [31:0] rnd_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [7:0]  pix_index,
    output logic [23:0] pix_color
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_CALC, S_OUT} state_t;

    state_t      state, state_nxt;
    logic        en;
    logic [15:0] period;
    logic [7:0]  count;
    logic [15:0] drops;
    logic [15:0] events;
    logic [15:0] timer;
    logic        tick;
    logic [31:0] rnd_q;
    logic [31:0] rd_data;
    logic [15:0] period_wval;
    logic [7:0]  idx_calc;
    logic [23:0] color_calc;
    logic        acc, wr, rd;
    logic [2:0]  reg_sel;
    logic        wr_ctrl, wr_period, wr_count, wr_status;
`ifdef SPARKLE_BRIGHTNESS_EN
    logic [7:0]  bright;
    logic        wr_bright;
`endif
    logic        unused_bits;

    // Address bits outside [4:2], the upper data half and upper byte enables carry no meaning here.
    assign unused_bits = &{1'b0, wbs_adr_i[31:5], wbs_adr_i[1:0], wbs_dat_i[31:16], wbs_sel_i[3:2]};

    assign acc       = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
    assign wr        = acc & wbs_we_i;
    assign rd        = acc & ~wbs_we_i;
    assign reg_sel   = wbs_adr_i[4:2];
    assign wr_ctrl   = wr && (reg_sel == 3'd0);
    assign wr_period = wr && (reg_sel == 3'd1);
    assign wr_count  = wr && (reg_sel == 3'd2);
    assign wr_status = wr && (reg_sel == 3'd3);
`ifdef SPARKLE_BRIGHTNESS_EN
    assign wr_bright = wr && (reg_sel == 3'd4);
`endif

    assign period_wval = {wbs_sel_i[1] ? wbs_dat_i[15:8] : period[15:8],
                          wbs_sel_i[0] ? wbs_dat_i[7:0]  : period[7:0]};

    assign tick = en && (period != 16'd0) && (timer == 16'd1);

    assign idx_calc = 8'(({8'b0, rnd_q[7:0]} * {8'b0, count}) >> 8);
`ifdef SPARKLE_BRIGHTNESS_EN
    assign color_calc = {8'(({8'b0, rnd_q[31:24]} * {8'b0, bright}) >> 8),
                         8'(({8'b0, rnd_q[23:16]} * {8'b0, bright}) >> 8),
                         8'(({8'b0, rnd_q[15:8]}  * {8'b0, bright}) >> 8)};
`else
    assign color_calc = rnd_q[31:8];
`endif

    // Configuration registers with per-byte write enables.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en     <= 1'b0;
            period <= RESET_PERIOD;
            count  <= 8'd0;
`ifdef SPARKLE_BRIGHTNESS_EN
            bright <= 8'hFF;
`endif
        end else begin
            if (wr_ctrl && wbs_sel_i[0])  en     <= wbs_dat_i[0];
            if (wr_period)                period <= period_wval;
            if (wr_count && wbs_sel_i[0]) count  <= wbs_dat_i[7:0];
`ifdef SPARKLE_BRIGHTNESS_EN
            if (wr_bright && wbs_sel_i[0]) bright <= wbs_dat_i[7:0];
`endif
        end
    end

    // Drop/event statistics; a STATUS write of any value wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drops  <= 16'd0;
            events <= 16'd0;
        end else if (wr_status) begin
            drops  <= 16'd0;
            events <= 16'd0;
        end else if (tick) begin
            if (state != S_IDLE && drops != 16'hFFFF)  drops  <= drops + 16'd1;
            if (state == S_IDLE && events != 16'hFFFF) events <= events + 16'd1;
        end
    end

    // Tick timer: counts down from PERIOD, ticks at 1, parks at PERIOD while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     timer <= RESET_PERIOD;
        else if (wr_period)             timer <= period_wval;
        else if (!en || timer <= 16'd1) timer <= period;
        else                            timer <= timer - 16'd1;
    end

    // Read mux; unmapped offsets return zero.
    always_comb begin
        rd_data = 32'd0;
        case (reg_sel)
            3'd0:    rd_data = {31'd0, en};
            3'd1:    rd_data = {16'd0, period};
            3'd2:    rd_data = {24'd0, count};
            3'd3:    rd_data = {drops, events};
`ifdef SPARKLE_BRIGHTNESS_EN
            3'd4:    rd_data = {24'd0, bright};
`endif
            default: rd_data = 32'd0;
        endcase
    end

    // Single-cycle acknowledge and registered read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= 32'd0;
        end else begin
            wbs_ack_o <= acc;
            if (rd) wbs_dat_o <= rd_data;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (tick) state_nxt = S_REQ;
            S_REQ:   state_nxt = S_CALC;
            S_CALC:  state_nxt = S_OUT;
            S_OUT:   if (pix_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs decoded from state so reset clears them immediately.
    always_comb begin
        rnd_next  = 1'b0;
        pix_valid = 1'b0;
        case (state)
            S_REQ:   rnd_next  = 1'b1;
            S_OUT:   pix_valid = 1'b1;
            default: ;
        endcase
    end

    // Capture the generator word in REQ and latch the pixel command in CALC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rnd_q     <= 32'd0;
            pix_index <= 8'd0;
            pix_color <= 24'd0;
        end else begin
            if (state == S_REQ) rnd_q <= rnd_data;
            if (state == S_CALC) begin
                pix_index <= idx_calc;
                pix_color <= color_calc;
            end
        end
    end

endmodule

// File: tb/tb_sparkle_scheduler.sv
// Testbench for sparkle_scheduler: transaction-level reference model plus scenario tasks.
module tb_sparkle_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [31:0] adr = 32'd0, dat_w = 32'd0;
    logic [3:0]  sel = 4'd0;
    logic [31:0] dat_r;
    logic        ack;
    logic        rnd_next;
    logic [31:0] rnd_data = 32'd0;
    logic        pix_valid;
    logic        pix_ready = 1'b0;
    logic [7:0]  pix_index;
    logic [23:0] pix_color;
    logic        rnd_fixed = 1'b0;

    int n_cmp = 0;
    int n_fail = 0;

`ifdef SPARKLE_BRIGHTNESS_EN
    localparam logic [31:0] BR_RST = 32'h0000_00FF;
`else
    localparam logic [31:0] BR_RST = 32'h0000_0000;
`endif

    sparkle_scheduler dut (
        .clk(clk), .rst_n(rst_n),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
        .wbs_adr_i(adr), .wbs_dat_i(dat_w), .wbs_sel_i(sel),
        .wbs_dat_o(dat_r), .wbs_ack_o(ack),
        .rnd_next(rnd_next), .rnd_data(rnd_data),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_index(pix_index), .pix_color(pix_color)
    );

    initial forever #5 clk = ~clk;

    // Free-running generator word, changed just after each rising edge.
    initial forever begin
        @(posedge clk);
        #1;
        if (!rnd_fixed) rnd_data = $urandom;
    end

    // ---------------- reference model ----------------
    // Ticks arrive every PERIOD edges after the last (re)start; an accepted tick
    // occupies the scheduler: word sampled after 1 cycle, pixel latched after 2,
    // valid from then until accepted.
    int          m_cyc = 0, m_ref = 0, m_age = 0;
    bit          m_en = 0, m_busy = 0, m_ack = 0;
    logic [15:0] m_period = 16'd1000;
    logic [7:0]  m_count = 8'd0, m_bright = 8'hFF;
    logic [15:0] m_drops = 16'd0, m_events = 16'd0;
    logic [31:0] m_rnd = 32'd0;
    logic [7:0]  m_idx = 8'd0;
    logic [23:0] m_col = 24'd0;

    task automatic model_step();
        bit tick, was_busy, commit;
        logic [15:0] pw;
        if (!rst_n) begin
            m_cyc = 0; m_ref = 0; m_age = 0; m_en = 0; m_busy = 0; m_ack = 0;
            m_period = 16'd1000; m_count = 8'd0; m_bright = 8'hFF;
            m_drops = 16'd0; m_events = 16'd0; m_rnd = 32'd0; m_idx = 8'd0; m_col = 24'd0;
            return;
        end
        m_cyc++;
        tick = m_en && (m_period != 16'd0) && (m_cyc > m_ref) &&
               (((m_cyc - m_ref) % int'(m_period)) == 0);
        was_busy = m_busy;
        if (m_busy) begin
            if (m_age >= 2 && pix_ready) m_busy = 0;
            else begin
                if (m_age == 0) m_rnd = rnd_data;
                if (m_age == 1) begin
                    m_idx = 8'((int'(m_rnd[7:0]) * int'(m_count)) >> 8);
`ifdef SPARKLE_BRIGHTNESS_EN
                    m_col = {8'((int'(m_rnd[31:24]) * int'(m_bright)) >> 8),
                             8'((int'(m_rnd[23:16]) * int'(m_bright)) >> 8),
                             8'((int'(m_rnd[15:8])  * int'(m_bright)) >> 8)};
`else
                    m_col = m_rnd[31:8];
`endif
                end
                if (m_age < 2) m_age++;
            end
        end
        if (tick) begin
            if (was_busy) begin
                if (m_drops != 16'hFFFF) m_drops = m_drops + 16'd1;
            end else begin
                if (m_events != 16'hFFFF) m_events = m_events + 16'd1;
                m_busy = 1; m_age = 0;
            end
        end
        commit = cyc && stb && !m_ack;
        m_ack = commit;
        if (commit && we) begin
            case (adr[4:2])
                3'd0: if (sel[0]) begin
                    if (dat_w[0] && !m_en) m_ref = m_cyc;
                    m_en = dat_w[0];
                end
                3'd1: begin
                    pw = m_period;
                    if (sel[0]) pw[7:0] = dat_w[7:0];
                    if (sel[1]) pw[15:8] = dat_w[15:8];
                    m_period = pw;
                    m_ref = m_cyc;
                end
                3'd2: if (sel[0]) m_count = dat_w[7:0];
                3'd3: begin m_drops = 16'd0; m_events = 16'd0; end
`ifdef SPARKLE_BRIGHTNESS_EN
                3'd4: if (sel[0]) m_bright = dat_w[7:0];
`endif
                default: ;
            endcase
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    function automatic logic [31:0] exp_rd(input logic [2:0] r);
        case (r)
            3'd0: return {31'd0, m_en};
            3'd1: return {16'd0, m_period};
            3'd2: return {24'd0, m_count};
            3'd3: return {m_drops, m_events};
`ifdef SPARKLE_BRIGHTNESS_EN
            3'd4: return {24'd0, m_bright};
`endif
            default: return 32'd0;
        endcase
    endfunction

    // ---------------- bus tasks ----------------
    task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        @(posedge clk); #1;
        cyc = 1; stb = 1; we = 1; adr = a; dat_w = d; sel = s;
        @(posedge clk); #1;
        cyc = 0; stb = 0; we = 0;
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] d, output logic k);
        @(posedge clk); #1;
        cyc = 1; stb = 1; we = 0; adr = a; sel = 4'hF;
        @(posedge clk); #1;
        d = dat_r; k = ack;
        cyc = 0; stb = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [31:0] addrs [8] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h1C};
        logic [31:0] exps  [8] = '{32'd0, 32'd1000, 32'd0, 32'd0, BR_RST, 32'd0, 32'd0, 32'd0};
        logic [31:0] d;
        logic k;
        @(negedge clk);
        n_cmp++;
        if ({rnd_next, pix_valid, pix_index, pix_color, ack, dat_r} !== 67'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got rn=%b pv=%b idx=%h col=%h ack=%b dat=%h expected all 0",
                     rnd_next, pix_valid, pix_index, pix_color, ack, dat_r);
        end
        rst_n = 1;
        for (int i = 0; i < 8; i++) begin
            wb_read(addrs[i], d, k);
            n_cmp++;
            if (k !== 1'b1 || d !== exps[i]) begin
                n_fail++;
                $display("FAIL reset_reg addr=%h got ack=%b dat=%h expected ack=1 dat=%h", addrs[i], k, d, exps[i]);
            end
        end
    endtask

    task automatic test_regs();
        logic [2:0] choices [6] = '{3'd1, 3'd2, 3'd4, 3'd5, 3'd6, 3'd7};
        logic [2:0] r;
        logic [31:0] a, d, e;
        logic k;
        for (int i = 0; i < 12; i++) begin
            r = choices[$urandom_range(0, 5)];
            a = ($urandom & ~32'h1C) | (32'(r) << 2);
            wb_write(a, $urandom, 4'($urandom));
            wb_read(a, d, k);
            e = exp_rd(r);
            n_cmp++;
            if (k !== 1'b1 || d !== e) begin
                n_fail++;
                $display("FAIL regs addr=%h got ack=%b dat=%h expected ack=1 dat=%h", a, k, d, e);
            end
        end
    endtask

    task automatic test_periodic();
        int last_rn = -1;
        int n_rn = 0;
        logic [31:0] d;
        logic k;
        wb_write(32'h0C, 32'd0, 4'hF);
        wb_write(32'h08, 32'd100, 4'hF);
        wb_write(32'h04, 32'd4, 4'hF);
        pix_ready = 1;
        wb_write(32'h00, 32'd1, 4'hF);
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            n_cmp++;
            if (rnd_next !== (m_busy && m_age == 0) || pix_valid !== (m_busy && m_age >= 2) ||
                (pix_valid && (pix_index !== m_idx || pix_color !== m_col))) begin
                n_fail++;
                $display("FAIL periodic i=%0d got rn=%b pv=%b idx=%h col=%h expected rn=%b pv=%b idx=%h col=%h",
                         i, rnd_next, pix_valid, pix_index, pix_color,
                         (m_busy && m_age == 0), (m_busy && m_age >= 2), m_idx, m_col);
            end
            if (rnd_next) begin
                if (last_rn >= 0) begin
                    n_cmp++;
                    if (i - last_rn != 4) begin
                        n_fail++;
                        $display("FAIL periodic_spacing got %0d expected 4", i - last_rn);
                    end
                end
                last_rn = i;
                n_rn++;
            end
            if (pix_valid && last_rn >= 0) begin
                n_cmp++;
                if (i - last_rn != 2) begin
                    n_fail++;
                    $display("FAIL periodic_latency got %0d expected 2", i - last_rn);
                end
            end
        end
        n_cmp++;
        if (n_rn < 15) begin
            n_fail++;
            $display("FAIL periodic_count got %0d rnd_next pulses expected at least 15", n_rn);
        end
        wb_write(32'h00, 32'd0, 4'hF);
        wb_read(32'h0C, d, k);
        n_cmp++;
        if (d !== {m_drops, m_events} || d[31:16] !== 16'd0) begin
            n_fail++;
            $display("FAIL periodic_status got %h expected %h", d, {m_drops, m_events});
        end
        for (int i = 0; i < 20 && m_busy; i++) @(negedge clk);
    endtask

    task automatic test_vectors();
        logic [7:0]  cnts [4] = '{8'd100, 8'd100, 8'd0, 8'd255};
        logic [7:0]  brs  [4] = '{8'h80, 8'hFF, 8'hFF, 8'h00};
        logic [7:0]  eidx [4] = '{8'h32, 8'h32, 8'h00, 8'h7F};
`ifdef SPARKLE_BRIGHTNESS_EN
        logic [23:0] ecol [4] = '{24'h091A2B, 24'h113355, 24'h113355, 24'h000000};
`else
        logic [23:0] ecol [4] = '{24'h123456, 24'h123456, 24'h123456, 24'h123456};
`endif
        bit seen;
        rnd_fixed = 1;
        rnd_data = 32'h1234_5680;
        pix_ready = 1;
        wb_write(32'h04, 32'd3, 4'hF);
        for (int v = 0; v < 4; v++) begin
            wb_write(32'h08, {24'd0, cnts[v]}, 4'hF);
            wb_write(32'h10, {24'd0, brs[v]}, 4'hF);
            wb_write(32'h00, 32'd1, 4'hF);
            seen = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (pix_valid) begin seen = 1; break; end
            end
            n_cmp++;
            if (!seen || pix_index !== eidx[v] || pix_color !== ecol[v]) begin
                n_fail++;
                $display("FAIL vector%0d got seen=%b idx=%h col=%h expected seen=1 idx=%h col=%h",
                         v, seen, pix_index, pix_color, eidx[v], ecol[v]);
            end
            wb_write(32'h00, 32'd0, 4'hF);
            for (int i = 0; i < 20 && m_busy; i++) @(negedge clk);
        end
        rnd_fixed = 0;
    endtask

    task automatic test_backpressure();
        bit seen;
        logic [31:0] d;
        logic k;
        pix_ready = 0;
        wb_write(32'h0C, 32'd0, 4'hF);
        wb_write(32'h08, 32'($urandom_range(1, 255)), 4'hF);
        wb_write(32'h04, 32'd2, 4'hF);
        wb_write(32'h00, 32'd1, 4'hF);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (pix_valid) begin seen = 1; break; end
        end
        n_cmp++;
        if (!seen) begin
            n_fail++;
            $display("FAIL backpressure_start got no pix_valid expected pix_valid within 20 cycles");
        end
        // COUNT change while held must not disturb the held command.
        wb_write(32'h08, {24'd0, ~m_count}, 4'hF);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_cmp++;
            if (pix_valid !== 1'b1 || rnd_next !== 1'b0 || pix_index !== m_idx || pix_color !== m_col) begin
                n_fail++;
                $display("FAIL backpressure_hold i=%0d got pv=%b rn=%b idx=%h col=%h expected pv=1 rn=0 idx=%h col=%h",
                         i, pix_valid, rnd_next, pix_index, pix_color, m_idx, m_col);
            end
        end
        wb_write(32'h00, 32'd0, 4'hF);
        wb_read(32'h0C, d, k);
        n_cmp++;
        if (d !== {m_drops, m_events} || d[15:0] !== 16'd1) begin
            n_fail++;
            $display("FAIL backpressure_status got %h expected %h (events 1)", d, {m_drops, m_events});
        end
        pix_ready = 1;
        for (int i = 0; i < 20 && m_busy; i++) @(negedge clk);
    endtask

    task automatic test_en_clear();
        bit seen;
        int hs = 0, n_rn = 0;
        logic [31:0] d;
        logic k;
        pix_ready = 0;
        wb_write(32'h04, 32'd5, 4'hF);
        wb_write(32'h08, 32'($urandom_range(1, 255)), 4'hF);
        wb_write(32'h00, 32'd1, 4'hF);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (pix_valid) begin seen = 1; break; end
        end
        wb_write(32'h00, 32'd0, 4'hF);
        pix_ready = 1;
        @(negedge clk);
        if (pix_valid && pix_ready) hs++;
        @(posedge clk); #1;
        pix_ready = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (rnd_next) n_rn++;
            if (pix_valid && pix_ready) hs++;
            n_cmp++;
            if (pix_valid !== (m_busy && m_age >= 2) || rnd_next !== (m_busy && m_age == 0)) begin
                n_fail++;
                $display("FAIL en_clear_cycle i=%0d got pv=%b rn=%b expected pv=%b rn=%b",
                         i, pix_valid, rnd_next, (m_busy && m_age >= 2), (m_busy && m_age == 0));
            end
        end
        n_cmp++;
        if (!seen || hs != 1 || n_rn != 0) begin
            n_fail++;
            $display("FAIL en_clear got seen=%b accepts=%0d rnd_next=%0d expected seen=1 accepts=1 rnd_next=0",
                     seen, hs, n_rn);
        end
        wb_write(32'h0C, 32'($urandom), 4'($urandom));
        wb_read(32'h0C, d, k);
        n_cmp++;
        if (d !== 32'd0) begin
            n_fail++;
            $display("FAIL status_clear got %h expected 00000000", d);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic k;
        bit seen;
        for (int pass = 0; pass < 2; pass++) begin
            pix_ready = 0;
            wb_write(32'h04, 32'd3, 4'hF);
            wb_write(32'h08, 32'd200, 4'hF);
            wb_write(32'h00, 32'd1, 4'hF);
            seen = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if ((pass == 0 && m_busy && m_age == 1) || (pass == 1 && pix_valid)) begin
                    seen = 1; break;
                end
            end
            rst_n = 0;
            #1;
            n_cmp++;
            if (!seen || {rnd_next, pix_valid, pix_index, pix_color, ack, dat_r} !== 67'd0) begin
                n_fail++;
                $display("FAIL reset_mid pass=%0d got seen=%b rn=%b pv=%b idx=%h col=%h ack=%b dat=%h expected seen=1 all 0",
                         pass, seen, rnd_next, pix_valid, pix_index, pix_color, ack, dat_r);
            end
            #2;
            rst_n = 1;
            wb_read(32'h04, d, k);
            n_cmp++;
            if (d !== 32'd1000) begin
                n_fail++;
                $display("FAIL reset_mid_period got %h expected 000003e8", d);
            end
            wb_read(32'h00, d, k);
            n_cmp++;
            if (d !== 32'd0) begin
                n_fail++;
                $display("FAIL reset_mid_ctrl got %h expected 00000000", d);
            end
            wb_read(32'h10, d, k);
            n_cmp++;
            if (d !== BR_RST) begin
                n_fail++;
                $display("FAIL reset_mid_bright got %h expected %h", d, BR_RST);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] pat = 4'b0101;
        @(posedge clk); #1;
        cyc = 1; stb = 1; we = 0; adr = 32'h04; sel = 4'hF;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (ack !== pat[i] || (pat[i] && dat_r !== {16'd0, m_period})) begin
                n_fail++;
                $display("FAIL back_to_back i=%0d got ack=%b dat=%h expected ack=%b dat=%h",
                         i, ack, dat_r, pat[i], {16'd0, m_period});
            end
        end
        cyc = 0; stb = 0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        test_reset();
        test_regs();
        test_periodic();
        test_vectors();
        test_backpressure();
        test_en_clear();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired before the scenarios completed");
        $fatal(1, "watchdog");
    end

endmodule
